ex_hazard_ctrl: RTL
===================

// Module: ex_hazard_ctrl
// PURPOSE
//  Pipeline hazard controller for the EX stage. Keeps a shadow copy of the
//  destination-register info for the instructions in EX and MEM. From that it
//  produces registered operand-forwarding selects for the EX ALU inputs, a
//  load-use stall/bubble, branch-redirect flush, and stall/flush perf counters.
//  Sits between ID decode and the ID/EX pipeline register.
// PARAMETERS
//  REG_AW  5   register-index width
//  CNT_W   16  width of perf counters (saturating)
// PORTS
//  clk            in   1       pipeline clock, rising edge
//  reset_n        in   1       asynchronous, active-low reset
//  hold           in   1       global freeze (e.g. memory not ready)
//  id_valid       in   1       ID holds a real instruction
//  id_rs1         in   REG_AW  ID source 1 index
//  id_rs2         in   REG_AW  ID source 2 index
//  id_use_rs1     in   1       ID instruction reads rs1
//  id_use_rs2     in   1       ID instruction reads rs2
//  id_rd          in   REG_AW  ID destination index
//  id_reg_write   in   1       ID instruction writes rd
//  id_mem_read    in   1       ID instruction is a load
//  ex_branch_taken in  1       EX resolves a taken branch/jump this cycle
//  stall          out  1       hold PC and IF/ID (combinational)
//  bubble         out  1       load zero ctrl into ID/EX (combinational)
//  flush_if_id    out  1       invalidate IF/ID (combinational)
//  fwd_a_sel      out  2       EX operand A: 00 regfile, 01 MEM alu_result, 10 WB data
//  fwd_b_sel      out  2       EX operand B: same encoding
//  stall_cnt      out  CNT_W   cycles with load-use stall
//  flush_cnt      out  CNT_W   taken-branch flush events
// BEHAVIOUR
//  State:
//   - Slot EX: {v, rd, rw, mr}. Slot MEM: {v, rd, rw}.
//   - Registered fwd_a_sel, fwd_b_sel. Both counters.
//  Reset (async, reset_n=0):
//   - Slots invalid; fwd_*_sel=00; counters=0.
//   - Hence stall=hold, bubble=0, flush_if_id=0.
//  Hazard terms (combinational):
//   - A register index of 0 never matches.
//   - hitE(rs) = EX.v & EX.rw & EX.rd==rs & rs!=0.
//   - hitM(rs) = MEM.v & MEM.rw & MEM.rd==rs & rs!=0.
//   - lu = id_valid & EX.mr & ((id_use_rs1 & hitE(id_rs1)) | (id_use_rs2 & hitE(id_rs2))).
//  Priority: hold > ex_branch_taken > lu.
//   - hold=1:
//     - stall=1, bubble=0, flush=0.
//     - All state and counters frozen.
//   - taken (no hold):
//     - flush_if_id=1, bubble=1, stall=0.
//     - EX slot <= invalid; MEM <= EX.
//     - fwd_*_sel <= 00; flush_cnt++.
//   - lu (no hold, no taken):
//     - stall=1, bubble=1.
//     - EX slot <= invalid; MEM <= EX.
//     - fwd_*_sel <= 00; stall_cnt++.
//   - Normal advance:
//     - MEM <= EX; EX <= {id_valid, id_rd, id_reg_write, id_mem_read}.
//     - fwd_x_sel <= hitE(rsx)&use ? 01 : hitM(rsx)&use ? 10 : 00.
//     - MEM forwarding takes priority over WB.
//  Latency:
//   - fwd selects are valid the cycle after ID, i.e. aligned with the
//     instruction occupying EX.
//   - stall/bubble/flush are valid in the same cycle.
//  Load-use timing:
//   - Exactly one bubble per load-use.
//   - On the retry cycle the load sits in MEM, so the dependent operand gets 10.
//  Counters: saturate at all-ones and do not wrap.
//  Reset mid-stall: stall, bubble and flush drop immediately with reset;
//   no pending state survives.
// TESTING
//  1. add x5 in ID, then sub using rs1=x5 next -> fwd_a_sel=01 in sub's EX cycle; no stall.
//  2. Producer of x7, one unrelated instr, then consumer of x7 on rs2 -> fwd_b_sel=10.
//  3. lw x3, then add rs1=x3 -> one cycle stall=1,bubble=1; stall_cnt=1.
//     Next cycle fwd_a_sel=10, stall=0.
//  4. Writer of x0, then reader of x0 -> fwd_*_sel=00, no stall.
//  5. lu and ex_branch_taken in the same cycle -> flush_if_id=1, stall=0.
//     flush_cnt=1, stall_cnt=0.
//     hold=1 during lu -> stall=1, bubble=0, nothing changes.
//  6. Force stall_cnt to all-ones, then one more lu -> value stays all-ones.
//     Assert reset_n=0 mid-lu -> all outputs 0 (stall=hold) asynchronously.

Source files
------------

// File: rtl/ex_hazard_ctrl_if.sv
// Bundle of ID-side hazard inputs and the hazard controller's outputs.
// master: the pipeline side that drives ID/EX info and consumes the controls.
// slave : the hazard controller.
interface ex_hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic              hold;
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic [REG_AW-1:0] id_rd;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              ex_branch_taken;
  logic              stall;
  logic              bubble;
  logic              flush_if_id;
  logic [1:0]        fwd_a_sel;
  logic [1:0]        fwd_b_sel;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output hold, id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_rd, id_reg_write, id_mem_read, ex_branch_taken,
    input  stall, bubble, flush_if_id, fwd_a_sel, fwd_b_sel,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  hold, id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_rd, id_reg_write, id_mem_read, ex_branch_taken,
    output stall, bubble, flush_if_id, fwd_a_sel, fwd_b_sel,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard controller: shadows the destination info of the EX and MEM
// instructions, produces registered forwarding selects, a load-use
// stall/bubble, a branch-redirect flush and saturating stall/flush counters.
module ex_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input logic             clk,
  input logic             reset_n,
  ex_hazard_ctrl_if.slave bus
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_WB  = 2'b10;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic              ex_v_q,  ex_v_d;
  logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
  logic              ex_rw_q, ex_rw_d;
  logic              ex_mr_q, ex_mr_d;
  logic              mem_v_q,  mem_v_d;
  logic [REG_AW-1:0] mem_rd_q, mem_rd_d;
  logic              mem_rw_q, mem_rw_d;
  logic [1:0]        fwd_a_q, fwd_a_d;
  logic [1:0]        fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic lu;

  // x0 is hardwired, so an index of zero can never create a dependency.
  function automatic logic slot_hit(input logic v, input logic rw,
                                    input logic [REG_AW-1:0] rd,
                                    input logic [REG_AW-1:0] rs);
    return v & rw & (rd == rs) & (rs != '0);
  endfunction

  // The nearer producer (now in EX, next in MEM) holds the newer value.
  function automatic logic [1:0] fwd_sel(input logic use_rs,
                                         input logic [REG_AW-1:0] rs);
    if (use_rs & slot_hit(ex_v_q, ex_rw_q, ex_rd_q, rs))
      return SEL_MEM;
    else if (use_rs & slot_hit(mem_v_q, mem_rw_q, mem_rd_q, rs))
      return SEL_WB;
    else
      return SEL_RF;
  endfunction

  // Hazard detection, pipeline controls and next state; hold freezes all.
  always_comb begin
    lu = bus.id_valid & ex_mr_q &
         ((bus.id_use_rs1 & slot_hit(ex_v_q, ex_rw_q, ex_rd_q, bus.id_rs1)) |
          (bus.id_use_rs2 & slot_hit(ex_v_q, ex_rw_q, ex_rd_q, bus.id_rs2)));

    bus.stall       = 1'b0;
    bus.bubble      = 1'b0;
    bus.flush_if_id = 1'b0;

    ex_v_d      = ex_v_q;
    ex_rd_d     = ex_rd_q;
    ex_rw_d     = ex_rw_q;
    ex_mr_d     = ex_mr_q;
    mem_v_d     = mem_v_q;
    mem_rd_d    = mem_rd_q;
    mem_rw_d    = mem_rw_q;
    fwd_a_d     = fwd_a_q;
    fwd_b_d     = fwd_b_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    if (bus.hold) begin
      bus.stall = 1'b1;
    end else if (bus.ex_branch_taken || lu) begin
      // EX receives a bubble; the old EX instruction still retires into MEM.
      bus.bubble      = 1'b1;
      bus.flush_if_id = bus.ex_branch_taken;
      bus.stall       = ~bus.ex_branch_taken;
      ex_v_d   = 1'b0;
      mem_v_d  = ex_v_q;
      mem_rd_d = ex_rd_q;
      mem_rw_d = ex_rw_q;
      fwd_a_d  = SEL_RF;
      fwd_b_d  = SEL_RF;
      if (bus.ex_branch_taken) begin
        if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_ONE;
      end else begin
        if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_ONE;
      end
    end else begin
      mem_v_d  = ex_v_q;
      mem_rd_d = ex_rd_q;
      mem_rw_d = ex_rw_q;
      ex_v_d   = bus.id_valid;
      ex_rd_d  = bus.id_rd;
      ex_rw_d  = bus.id_reg_write;
      ex_mr_d  = bus.id_mem_read;
      fwd_a_d  = fwd_sel(bus.id_use_rs1, bus.id_rs1);
      fwd_b_d  = fwd_sel(bus.id_use_rs2, bus.id_rs2);
    end
  end

  // State register for the shadow slots, forwarding selects and counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_v_q      <= 1'b0;
      ex_rd_q     <= '0;
      ex_rw_q     <= 1'b0;
      ex_mr_q     <= 1'b0;
      mem_v_q     <= 1'b0;
      mem_rd_q    <= '0;
      mem_rw_q    <= 1'b0;
      fwd_a_q     <= SEL_RF;
      fwd_b_q     <= SEL_RF;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_v_q      <= ex_v_d;
      ex_rd_q     <= ex_rd_d;
      ex_rw_q     <= ex_rw_d;
      ex_mr_q     <= ex_mr_d;
      mem_v_q     <= mem_v_d;
      mem_rd_q    <= mem_rd_d;
      mem_rw_q    <= mem_rw_d;
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.fwd_a_sel = fwd_a_q;
  assign bus.fwd_b_sel = fwd_b_q;
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;

endmodule
